// File: rtl/alu_exec_sequencer_pkg.sv
// Shared definitions for the execute-stage sequencer: RV32I opcodes, ALU FUNC
// encodings, FSM states, operand selects and the pass-plan produced by the decoder.
package alu_exec_sequencer_pkg;

  // RV32I major opcodes handled by the sequencer.
  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  // ALU FUNC encodings; these match funct3 of the corresponding OP instructions.
  localparam logic [2:0] FuncAdd = 3'b000;
  localparam logic [2:0] FuncSl  = 3'b001;
  localparam logic [2:0] FuncXor = 3'b100;
  localparam logic [2:0] FuncSr  = 3'b101;
  localparam logic [2:0] FuncOr  = 3'b110;
  localparam logic [2:0] FuncAnd = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPass1 = 2'd1,
    StPass2 = 2'd2,
    StDone  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ASelZero = 2'd0,
    ASelRs1  = 2'd1,
    ASelPc   = 2'd2
  } a_sel_e;

  typedef enum logic [1:0] {
    BSelRs2 = 2'd0,
    BSelImm = 2'd1,
    BSelInc = 2'd2
  } b_sel_e;

  typedef enum logic [1:0] {
    ResSum = 2'd0,
    ResLs  = 2'd1,
    ResLu  = 2'd2
  } res_sel_e;

  // Pass 2 always runs an unsigned ADD of the selected A with the immediate, so only
  // its A select needs to be carried.
  typedef struct packed {
    a_sel_e   a1;
    b_sel_e   b1;
    logic [2:0] func1;
    logic     sub1;
    a_sel_e   a2;
    logic     two_pass;   // unconditional second pass (JAL/JALR)
    logic     branch;     // second pass only when the branch is taken
    logic     jalr_mask;  // clear bit 0 of the pass-2 sum
    res_sel_e res_sel;
    logic     rd_we;
    logic     illegal;
  } plan_t;

  function automatic logic branch_taken(logic [2:0] funct3, logic eq, logic lu, logic ls);
    logic taken;
    case (funct3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = ls;
      3'b101:  taken = ~ls;
      3'b110:  taken = lu;
      3'b111:  taken = ~lu;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_exec_sequencer_decode.sv
// Combinational instruction decoder for the execute sequencer.
// Ports:
//   opcode_i, funct3_i, funct7_5_i : instruction fields
//   plan_o                         : pass plan (operand selects, FUNC/sub, pass count,
//                                    result source, rd_we, illegal)
module alu_exec_decode
  import alu_exec_sequencer_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output plan_t      plan_o
);

  logic is_op_imm;
  assign is_op_imm = (opcode_i == OpcOpImm);

  always_comb begin
    plan_o         = '0;
    plan_o.a1      = ASelRs1;
    plan_o.b1      = BSelRs2;
    plan_o.func1   = FuncAdd;
    plan_o.a2      = ASelPc;
    plan_o.res_sel = ResSum;
    plan_o.illegal = 1'b1;

    case (opcode_i)
      OpcOp, OpcOpImm: begin
        plan_o.illegal = 1'b0;
        plan_o.rd_we   = 1'b1;
        plan_o.b1      = is_op_imm ? BSelImm : BSelRs2;
        case (funct3_i)
          3'b000: begin
            plan_o.func1 = FuncAdd;
            // ADDI has no subtract form; bit 30 is part of its immediate.
            plan_o.sub1  = is_op_imm ? 1'b0 : funct7_5_i;
          end
          3'b010: begin
            plan_o.func1   = FuncAdd;
            plan_o.sub1    = 1'b1;
            plan_o.res_sel = ResLs;
          end
          3'b011: begin
            plan_o.func1   = FuncAdd;
            plan_o.sub1    = 1'b1;
            plan_o.res_sel = ResLu;
          end
          3'b101: begin
            plan_o.func1 = FuncSr;
            plan_o.sub1  = funct7_5_i;
          end
          default: begin
            plan_o.func1 = funct3_i;
            plan_o.sub1  = 1'b0;
          end
        endcase
      end
      OpcLui: begin
        plan_o.illegal = 1'b0;
        plan_o.rd_we   = 1'b1;
        plan_o.a1      = ASelZero;
        plan_o.b1      = BSelImm;
      end
      OpcAuipc: begin
        plan_o.illegal = 1'b0;
        plan_o.rd_we   = 1'b1;
        plan_o.a1      = ASelPc;
        plan_o.b1      = BSelImm;
      end
      OpcJal, OpcJalr: begin
        plan_o.illegal   = 1'b0;
        plan_o.rd_we     = 1'b1;
        plan_o.a1        = ASelPc;
        plan_o.b1        = BSelInc;
        plan_o.two_pass  = 1'b1;
        plan_o.a2        = (opcode_i == OpcJalr) ? ASelRs1 : ASelPc;
        plan_o.jalr_mask = (opcode_i == OpcJalr);
      end
      OpcBranch: begin
        plan_o.illegal = (funct3_i == 3'b010) || (funct3_i == 3'b011);
        plan_o.sub1    = 1'b1;
        plan_o.branch  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute-stage controller. Accepts one decoded instruction per handshake,
// drives the shared ALU over one or two passes and presents the write-back value and
// redirect target.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   in_valid/in_ready + fields      : decoded instruction input handshake
//   alu_a/alu_b/alu_func/alu_sub_sra: registered ALU controls
//   alu_s/alu_eq/alu_lu/alu_ls      : ALU result and compare flags
//   out_valid/out_ready + results   : write-back handshake (rd, redirect, illegal)
module alu_exec_sequencer
  import alu_exec_sequencer_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned RESET_PC_INC = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_func,
  output logic            alu_sub_sra,
  input  logic [XLEN-1:0] alu_s,
  input  logic            alu_eq,
  input  logic            alu_lu,
  input  logic            alu_ls,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] rd_val,
  output logic            rd_we,
  output logic            redirect,
  output logic [XLEN-1:0] pc_next,
  output logic            illegal
);

  state_e          state_q, state_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            funct7_5_q, funct7_5_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] alu_a_q, alu_a_d;
  logic [XLEN-1:0] alu_b_q, alu_b_d;
  logic [2:0]      alu_func_q, alu_func_d;
  logic            alu_sub_sra_q, alu_sub_sra_d;
  logic [XLEN-1:0] rd_val_q, rd_val_d;
  logic            rd_we_q, rd_we_d;
  logic            redirect_q, redirect_d;
  logic [XLEN-1:0] pc_next_q, pc_next_d;
  logic            illegal_q, illegal_d;

  // In IDLE the live fields are decoded to load pass 1; afterwards the latched copy
  // keeps the plan stable for the rest of the instruction.
  logic       idle;
  logic [6:0] dec_opcode;
  logic [2:0] dec_funct3;
  logic       dec_funct7_5;
  plan_t      plan;

  assign idle         = (state_q == StIdle);
  assign dec_opcode   = idle ? opcode   : opcode_q;
  assign dec_funct3   = idle ? funct3   : funct3_q;
  assign dec_funct7_5 = idle ? funct7_5 : funct7_5_q;

  alu_exec_decode u_decode (
    .opcode_i   (dec_opcode),
    .funct3_i   (dec_funct3),
    .funct7_5_i (dec_funct7_5),
    .plan_o     (plan)
  );

  function automatic logic [XLEN-1:0] sel_a(a_sel_e sel, logic [XLEN-1:0] rs1v,
                                            logic [XLEN-1:0] pcv);
    case (sel)
      ASelRs1: return rs1v;
      ASelPc:  return pcv;
      default: return '0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] sel_b(b_sel_e sel, logic [XLEN-1:0] rs2v,
                                            logic [XLEN-1:0] immv);
    case (sel)
      BSelImm: return immv;
      BSelInc: return XLEN'(RESET_PC_INC);
      default: return rs2v;
    endcase
  endfunction

  logic [XLEN-1:0] pass1_result;
  always_comb begin
    case (plan.res_sel)
      ResLs:   pass1_result = {{(XLEN-1){1'b0}}, alu_ls};
      ResLu:   pass1_result = {{(XLEN-1){1'b0}}, alu_lu};
      default: pass1_result = alu_s;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    opcode_d      = opcode_q;
    funct3_d      = funct3_q;
    funct7_5_d    = funct7_5_q;
    rs1_d         = rs1_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_func_d    = alu_func_q;
    alu_sub_sra_d = alu_sub_sra_q;
    rd_val_d      = rd_val_q;
    rd_we_d       = rd_we_q;
    redirect_d    = redirect_q;
    pc_next_d     = pc_next_q;
    illegal_d     = illegal_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          opcode_d   = opcode;
          funct3_d   = funct3;
          funct7_5_d = funct7_5;
          rs1_d      = rs1_val;
          imm_d      = imm;
          pc_d       = pc;
          rd_val_d   = '0;
          rd_we_d    = 1'b0;
          redirect_d = 1'b0;
          pc_next_d  = '0;
          illegal_d  = 1'b0;
          if (plan.illegal) begin
            illegal_d = 1'b1;
            state_d   = StDone;
          end else begin
            alu_a_d       = sel_a(plan.a1, rs1_val, pc);
            alu_b_d       = sel_b(plan.b1, rs2_val, imm);
            alu_func_d    = plan.func1;
            alu_sub_sra_d = plan.sub1;
            state_d       = StPass1;
          end
        end
      end
      StPass1: begin
        if (plan.branch) begin
          state_d = StDone;
          if (branch_taken(funct3_q, alu_eq, alu_lu, alu_ls)) begin
            state_d = StPass2;
          end
        end else begin
          rd_val_d = pass1_result;
          rd_we_d  = plan.rd_we;
          state_d  = plan.two_pass ? StPass2 : StDone;
        end
        if (state_d == StPass2) begin
          alu_a_d       = sel_a(plan.a2, rs1_q, pc_q);
          alu_b_d       = imm_q;
          alu_func_d    = FuncAdd;
          alu_sub_sra_d = 1'b0;
        end
      end
      StPass2: begin
        pc_next_d  = plan.jalr_mask ? {alu_s[XLEN-1:1], 1'b0} : alu_s;
        redirect_d = 1'b1;
        state_d    = StDone;
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      opcode_q      <= '0;
      funct3_q      <= '0;
      funct7_5_q    <= 1'b0;
      rs1_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_func_q    <= FuncAdd;
      alu_sub_sra_q <= 1'b0;
      rd_val_q      <= '0;
      rd_we_q       <= 1'b0;
      redirect_q    <= 1'b0;
      pc_next_q     <= '0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      opcode_q      <= opcode_d;
      funct3_q      <= funct3_d;
      funct7_5_q    <= funct7_5_d;
      rs1_q         <= rs1_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_func_q    <= alu_func_d;
      alu_sub_sra_q <= alu_sub_sra_d;
      rd_val_q      <= rd_val_d;
      rd_we_q       <= rd_we_d;
      redirect_q    <= redirect_d;
      pc_next_q     <= pc_next_d;
      illegal_q     <= illegal_d;
    end
  end

  assign in_ready    = idle;
  assign out_valid   = (state_q == StDone);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_func    = alu_func_q;
  assign alu_sub_sra = alu_sub_sra_q;
  assign rd_val      = rd_val_q;
  assign rd_we       = rd_we_q;
  assign redirect    = redirect_q;
  assign pc_next     = pc_next_q;
  assign illegal     = illegal_q;

endmodule
